// File: rtl/uart_tx_drain.sv
// Drains the echo FIFO onto the board TX pin as 8N1 (8E1 when UART_TX_PARITY_EN is defined).
// One read strobe per frame; the byte is taken from the FIFO's registered read port one cycle later.
module uart_tx_drain #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic [ADDR_WIDTH:0]   fifo_count,
    input  logic [7:0]            fifo_r_data,
    output logic                  fifo_r_enable,
    output logic                  tx,
    output logic                  busy
);

    localparam int DIV   = CLK_FREQ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        START,
        DATA,
`ifdef UART_TX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shreg;

    // fifo_count is only looked at in IDLE, so its one-cycle update lag after a read is harmless.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state         <= IDLE;
            fifo_r_enable <= 1'b0;
            tx            <= 1'b1;
            cnt           <= '0;
            bit_idx       <= '0;
            shreg         <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fifo_count != '0) begin
                        fifo_r_enable <= 1'b1;
                        state         <= FETCH;
                    end
                end
                FETCH: begin
                    fifo_r_enable <= 1'b0;
                    state         <= LOAD;
                end
                LOAD: begin
                    shreg <= fifo_r_data;
                    tx    <= 1'b0;
                    cnt   <= '0;
                    state <= START;
                end
                START: begin
                    if (cnt == CNT_MAX) begin
                        cnt     <= '0;
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= DATA;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == CNT_MAX) begin
                        cnt <= '0;
                        if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx    <= ^shreg;
                            state <= PARITY;
`else
                            tx    <= 1'b1;
                            state <= STOP;
`endif
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                            tx      <= shreg[bit_idx + 3'd1];
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        tx    <= 1'b1;
                        state <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                STOP: begin
                    if (cnt == CNT_MAX) begin
                        cnt   <= '0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    tx            <= 1'b1;
                    fifo_r_enable <= 1'b0;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_tx_drain.sv
// Directed bench for uart_tx_drain with DIV = 10 and a queue-based FIFO model.
// Define UART_TX_PARITY_EN for both files to exercise the 8E1 frames.
module tb_uart_tx_drain;

    localparam int DIV = 10;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_LEN = NBITS * DIV;

    logic       CLK;
    logic       RST;
    logic [8:0] fifo_count;
    logic [7:0] fifo_r_data;
    logic       fifo_r_enable;
    logic       tx;
    logic       busy;

    int unsigned checks = 0;
    int unsigned errors = 0;

    logic [7:0] q[$];
    logic [8:0] cnt_now = '0;
    logic [8:0] cnt_lag = '0;
    bit         lag_mode = 1'b0;
    int         cyc = 0;
    int         strobes = 0;
    int         strobe_cyc = 0;
    int         last_start = 0;

    uart_tx_drain #(
        .CLK_FREQ  (1000),
        .BAUD      (100),
        .ADDR_WIDTH(8)
    ) dut (
        .CLK          (CLK),
        .RST          (RST),
        .fifo_count   (fifo_count),
        .fifo_r_data  (fifo_r_data),
        .fifo_r_enable(fifo_r_enable),
        .tx           (tx),
        .busy         (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // FIFO model: registered read data, occupancy updated after the read edge (optionally one more cycle late).
    always @(posedge CLK) begin
        cyc <= cyc + 1;
        if (fifo_r_enable && q.size() != 0)
            fifo_r_data <= q.pop_front();
        cnt_now <= 9'(q.size());
        cnt_lag <= cnt_now;
    end

    assign fifo_count = lag_mode ? cnt_lag : cnt_now;

    always @(negedge CLK) begin
        if (fifo_r_enable === 1'b1) begin
            strobes    = strobes + 1;
            strobe_cyc = cyc;
        end
    end

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [7:0] b);
        q.push_back(b);
    endtask

    task automatic wait_start(output bit found);
        found = 1'b0;
        for (int i = 0; i < 300; i++) begin
            if (tx === 1'b0) begin
                found = 1'b1;
                break;
            end
            @(negedge CLK);
        end
        checkOutput("start_seen", {31'd0, found}, 32'd1);
    endtask

    // Follows one frame cycle by cycle against the waveform expected for byte b.
    task automatic check_frame(input logic [7:0] b);
        logic [10:0] fb;
        logic [7:0]  rx;
        logic        rx_par;
        int          bad;
        int          idle_busy;
        bit          found;
        fb       = '1;
        fb[0]    = 1'b0;
        fb[8:1]  = b;
`ifdef UART_TX_PARITY_EN
        fb[9]    = ^b;
`endif
        rx        = '0;
        rx_par    = 1'b0;
        bad       = 0;
        idle_busy = 0;
        wait_start(found);
        if (!found) return;
        last_start = cyc;
        // Strobe sits in FETCH, LOAD follows, then the start bit.
        checkOutput("strobe_to_start", 32'(last_start - strobe_cyc), 32'd2);
        for (int k = 0; k < FRAME_LEN; k++) begin
            if (k != 0) @(negedge CLK);
            if (tx !== fb[k / DIV]) bad++;
            if (busy !== 1'b1) idle_busy++;
            if (k % DIV == 5 && k / DIV >= 1 && k / DIV <= 8) rx[k / DIV - 1] = tx;
            if (k % DIV == 5 && k / DIV == 9) rx_par = tx;
        end
        checkOutput("wave", 32'(bad), 32'd0);
        checkOutput("busy_in_frame", 32'(idle_busy), 32'd0);
        checkOutput("byte", {24'd0, rx}, {24'd0, b});
`ifdef UART_TX_PARITY_EN
        checkOutput("parity_bit", {31'd0, rx_par}, {31'd0, ^b});
`else
        checkOutput("stop_bit", {31'd0, rx_par}, 32'd1);
`endif
        @(negedge CLK);
        checkOutput("busy_after", {31'd0, busy}, 32'd0);
        checkOutput("tx_after", {31'd0, tx}, 32'd1);
    endtask

    initial begin
        int  s0;
        int  st1;
        int  lows;
        int  busys;
        bit  found;

        RST = 1'b1;
        repeat (3) @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        checkOutput("reset_tx", {31'd0, tx}, 32'd1);
        checkOutput("reset_ren", {31'd0, fifo_r_enable}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);

        lows  = 0;
        busys = 0;
        for (int i = 0; i < 500; i++) begin
            @(negedge CLK);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        checkOutput("idle_tx_low", 32'(lows), 32'd0);
        checkOutput("idle_busy", 32'(busys), 32'd0);
        checkOutput("idle_strobes", 32'(strobes), 32'd0);

        $display("[TB] single byte 0x55");
        s0 = strobes;
        applyStimulus(8'h55);
        check_frame(8'h55);
        repeat (30) @(negedge CLK);
        checkOutput("single_strobes", 32'(strobes - s0), 32'd1);

        $display("[TB] back-to-back 0xA3, 0x0F");
        s0 = strobes;
        applyStimulus(8'hA3);
        applyStimulus(8'h0F);
        check_frame(8'hA3);
        st1 = last_start;
        check_frame(8'h0F);
        checkOutput("b2b_gap", 32'(last_start - st1 - FRAME_LEN), 32'd3);
        repeat (50) @(negedge CLK);
        checkOutput("b2b_strobes", 32'(strobes - s0), 32'd2);

        $display("[TB] reset during data bit 4 of 0xFF");
        s0 = strobes;
        applyStimulus(8'hFF);
        wait_start(found);
        repeat (DIV * 5 + 5) @(negedge CLK);
        checkOutput("mid_busy", {31'd0, busy}, 32'd1);
        RST = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        checkOutput("rst_tx", {31'd0, tx}, 32'd1);
        checkOutput("rst_busy", {31'd0, busy}, 32'd0);
        lows  = 0;
        busys = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (tx !== 1'b1) lows++;
            if (busy !== 1'b0) busys++;
        end
        checkOutput("rst_line_low", 32'(lows), 32'd0);
        checkOutput("rst_busy_after", 32'(busys), 32'd0);
        checkOutput("rst_strobes", 32'(strobes - s0), 32'd1);

        $display("[TB] lagging fifo_count");
        lag_mode = 1'b1;
        repeat (3) @(negedge CLK);
        s0 = strobes;
        applyStimulus(8'hC6);
        check_frame(8'hC6);
        repeat (50) @(negedge CLK);
        checkOutput("lag_strobes", 32'(strobes - s0), 32'd1);
        lag_mode = 1'b0;

`ifdef UART_TX_PARITY_EN
        $display("[TB] parity frames 0x07, 0x03");
        applyStimulus(8'h07);
        check_frame(8'h07);
        repeat (5) @(negedge CLK);
        applyStimulus(8'h03);
        check_frame(8'h03);
`endif

        repeat (5) @(negedge CLK);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
